// File: rtl/cpu_pkg.sv
// Shared definitions for the 20-bit CPU status/flow logic: widths,
// flow opcodes, status bit positions and the flow unit state enum.
package cpu_pkg;

  localparam int WORD_W = 20;
  localparam int HALF_W = 10;

  localparam logic [WORD_W-1:0] TRAP_VEC = 20'h00040;

  localparam logic [3:0] OP_NOP  = 4'd0;
  localparam logic [3:0] OP_ALU  = 4'd1;
  localparam logic [3:0] OP_JMP  = 4'd2;
  localparam logic [3:0] OP_JZ   = 4'd3;
  localparam logic [3:0] OP_JS   = 4'd4;
  localparam logic [3:0] OP_JZS  = 4'd5;
  localparam logic [3:0] OP_LSR  = 4'd6;
  localparam logic [3:0] OP_XSR  = 4'd7;
  localparam logic [3:0] OP_TRAP = 4'd8;

  localparam int ST_Z = 0;
  localparam int ST_S = 1;
  localparam int ST_C = 2;
  localparam int ST_M = 3;
  localparam int ST_T = 4;

  typedef enum logic {S_RUN = 1'b0, S_TRAP = 1'b1} state_t;

endpackage

// File: rtl/flag_branch_unit_if.sv
// Retire-side bus between the ALU/issue stage and the flow unit.
interface flag_branch_unit_if;
  import cpu_pkg::*;

  logic              in_valid;
  logic              in_ready;
  logic [3:0]        op;
  logic              mode;
  logic [WORD_W-1:0] alu_res;
  logic              alu_zero;
  logic              alu_carry;
  logic [2:0]        flag_mask;
  logic [WORD_W-1:0] target;
  logic              trap_clr;
  logic [WORD_W-1:0] pc;
  logic [4:0]        status;
  logic [WORD_W-1:0] epc;
  logic              redirect;

  modport master (
    output in_valid, op, mode, alu_res, alu_zero, alu_carry, flag_mask, target, trap_clr,
    input  in_ready, pc, status, epc, redirect
  );

  modport slave (
    input  in_valid, op, mode, alu_res, alu_zero, alu_carry, flag_mask, target, trap_clr,
    output in_ready, pc, status, epc, redirect
  );
endinterface

// File: rtl/flag_branch_unit_branch_cond.sv
// Combinational flow decode: whether the op redirects to its target and
// whether it belongs to the trap class (TRAP plus every opcode above it).
module branch_cond
  import cpu_pkg::*;
(
  input  logic [3:0] op,
  input  logic [4:0] status,
  output logic       take,
  output logic       illegal
);

  // Jump condition evaluated against status as it stood before this op
  always_comb begin
    take    = 1'b0;
    illegal = op[3];
    case (op)
      OP_JMP:  take = 1'b1;
      OP_JZ:   take = status[ST_Z];
      OP_JS:   take = status[ST_S];
      OP_JZS:  take = status[ST_Z] | status[ST_S];
      default: take = 1'b0;
    endcase
  end

endmodule

// File: rtl/flag_branch_unit.sv
// Status register, program counter and trap state for the 20-bit CPU.
// Consumes one retired op per cycle in RUN; TRAP blocks intake until
// trap_clr resumes execution at epc.
module flag_branch_unit
  import cpu_pkg::*;
(
  input logic               clk,
  input logic               rst,
  flag_branch_unit_if.slave bus
);

  state_t            state, state_nx;
  logic [WORD_W-1:0] pc_q, epc_q, pc_inc;
  logic [4:0]        st_q;
  logic              redir_q;
  logic              fire, take, illegal, s_sel;

  branch_cond u_cond (
    .op      (bus.op),
    .status  (st_q),
    .take    (take),
    .illegal (illegal)
  );

  assign fire   = bus.in_valid & (state == S_RUN);
  assign pc_inc = pc_q + 20'd1;
  assign s_sel  = bus.mode ? bus.alu_res[WORD_W-1] : bus.alu_res[HALF_W-1];

  assign bus.in_ready = (state == S_RUN);
  assign bus.pc       = pc_q;
  assign bus.status   = st_q;
  assign bus.epc      = epc_q;
  assign bus.redirect = redir_q;

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= S_RUN;
    else     state <= state_nx;
  end

  // Next state: enter TRAP on a trap-class op, leave on trap_clr
  always_comb begin
    state_nx = state;
    case (state)
      S_RUN:   if (fire && illegal) state_nx = S_TRAP;
      S_TRAP:  if (bus.trap_clr)    state_nx = S_RUN;
      default: state_nx = S_RUN;
    endcase
  end

  // PC, status, epc and the one-cycle redirect pulse
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q    <= '0;
      epc_q   <= '0;
      st_q    <= '0;
      redir_q <= 1'b0;
    end else begin
      redir_q <= 1'b0;
      if (state == S_TRAP) begin
        if (bus.trap_clr) begin
          pc_q       <= epc_q;
          st_q[ST_T] <= 1'b0;
          redir_q    <= 1'b1;
        end
      end else if (fire) begin
        if (illegal) begin
          epc_q      <= pc_inc;
          pc_q       <= TRAP_VEC;
          st_q[ST_T] <= 1'b1;
          redir_q    <= 1'b1;
        end else if (take) begin
          pc_q    <= bus.target;
          redir_q <= 1'b1;
        end else begin
          pc_q <= pc_inc;
          case (bus.op)
            OP_ALU: begin
              if (bus.flag_mask[0]) st_q[ST_Z] <= bus.alu_zero;
              if (bus.flag_mask[1]) st_q[ST_S] <= s_sel;
              if (bus.flag_mask[2]) st_q[ST_C] <= bus.alu_carry;
              st_q[ST_M] <= bus.mode;
            end
            // T (bit 4) is owned by trap entry/exit only
            OP_LSR:  st_q[3:0] <= bus.alu_res[3:0];
            OP_XSR:  st_q[3:0] <= st_q[3:0] ^ bus.alu_res[3:0];
            default: ;
          endcase
        end
      end
    end
  end

endmodule

// File: tb/tb_flag_branch_unit.sv
// Bench for flag_branch_unit: directed scenarios followed by random ops,
// every cycle compared against a behavioural model of the flow unit.
module tb_flag_branch_unit;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_vec = 0;
  int   n_err = 0;

  flag_branch_unit_if bus ();

  flag_branch_unit dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Reference state
  logic [19:0] m_pc, m_epc;
  logic        m_z, m_s, m_c, m_m, m_t, m_trap, m_redir;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model(input logic v, input logic [3:0] o, input logic md,
                       input logic [19:0] res, input logic z, input logic c,
                       input logic [2:0] mk, input logic [19:0] tgt,
                       input logic tclr, input logic r);
    logic cond;
    m_redir = 1'b0;
    if (r) begin
      m_pc = 0; m_epc = 0; m_trap = 0;
      {m_t, m_m, m_c, m_s, m_z} = 5'b0;
    end else if (m_trap) begin
      if (tclr) begin
        m_pc = m_epc; m_t = 0; m_redir = 1; m_trap = 0;
      end
    end else if (v) begin
      cond = 1'b0;
      case (o)
        2: cond = 1'b1;
        3: cond = m_z;
        4: cond = m_s;
        5: cond = m_z | m_s;
        default: cond = 1'b0;
      endcase
      if (o >= 8) begin
        m_epc = m_pc + 20'd1; m_pc = 20'h00040; m_t = 1; m_trap = 1; m_redir = 1;
      end else if (cond) begin
        m_pc = tgt; m_redir = 1;
      end else begin
        m_pc = m_pc + 20'd1;
        if (o == 1) begin
          if (mk[0]) m_z = z;
          if (mk[1]) m_s = md ? res[19] : res[9];
          if (mk[2]) m_c = c;
          m_m = md;
        end else if (o == 6) begin
          {m_m, m_c, m_s, m_z} = res[3:0];
        end else if (o == 7) begin
          {m_m, m_c, m_s, m_z} = {m_m, m_c, m_s, m_z} ^ res[3:0];
        end
      end
    end
  endtask

  // Drive one cycle, advance the model, compare after the edge
  task automatic step(input logic v, input logic [3:0] o, input logic md,
                      input logic [19:0] res, input logic z, input logic c,
                      input logic [2:0] mk, input logic [19:0] tgt,
                      input logic tclr, input logic r);
    @(negedge clk);
    rst = r;
    bus.in_valid = v; bus.op = o; bus.mode = md; bus.alu_res = res;
    bus.alu_zero = z; bus.alu_carry = c; bus.flag_mask = mk;
    bus.target = tgt; bus.trap_clr = tclr;
    model(v, o, md, res, z, c, mk, tgt, tclr, r);
    @(posedge clk);
    #1;
    chk("pc", 32'(bus.pc), 32'(m_pc));
    chk("status", 32'(bus.status), 32'({m_t, m_m, m_c, m_s, m_z}));
    chk("epc", 32'(bus.epc), 32'(m_epc));
    chk("redirect", 32'(bus.redirect), 32'(m_redir));
    chk("in_ready", 32'(bus.in_ready), 32'(!m_trap));
  endtask

  task automatic op1(input logic [3:0] o, input logic [19:0] res, input logic [19:0] tgt);
    step(1'b1, o, 1'b1, res, 1'b0, 1'b0, 3'b111, tgt, 1'b0, 1'b0);
  endtask

  task automatic idle(input logic tclr, input logic r);
    step(1'b0, 4'd0, 1'b0, 20'h0, 1'b0, 1'b0, 3'b0, 20'h0, tclr, r);
  endtask

  initial begin
    bus.in_valid = 0; bus.op = 0; bus.mode = 0; bus.alu_res = 0;
    bus.alu_zero = 0; bus.alu_carry = 0; bus.flag_mask = 0;
    bus.target = 0; bus.trap_clr = 0;
    m_pc = 0; m_epc = 0; m_trap = 0; m_redir = 0;
    {m_t, m_m, m_c, m_s, m_z} = 5'b0;

    // Reset for two cycles
    idle(1'b0, 1'b1);
    idle(1'b0, 1'b1);

    // ALU flag capture, full word then half word sign select
    step(1'b1, 4'd1, 1'b1, 20'h80000, 1'b0, 1'b1, 3'b111, 20'h0, 1'b0, 1'b0);
    chk("alu_full_status", 32'(bus.status), 32'(5'b01110));
    step(1'b1, 4'd1, 1'b0, 20'h00200, 1'b0, 1'b1, 3'b111, 20'h0, 1'b0, 1'b0);
    chk("alu_half_S", 32'(bus.status[1]), 32'(1'b1));
    // Masked ALU update: only Z enabled
    step(1'b1, 4'd1, 1'b1, 20'h00000, 1'b1, 1'b0, 3'b001, 20'h0, 1'b0, 1'b0);

    // Conditional jumps
    op1(4'd6, 20'h00001, 20'h0);       // Z=1
    op1(4'd3, 20'h0, 20'h00100);       // JZ taken
    chk("jz_taken_pc", 32'(bus.pc), 32'h00100);
    op1(4'd0, 20'h0, 20'h0);           // redirect drops
    op1(4'd6, 20'h00000, 20'h0);       // Z=0
    op1(4'd3, 20'h0, 20'h00100);       // JZ not taken
    op1(4'd6, 20'h00002, 20'h0);       // S only
    op1(4'd5, 20'h0, 20'h00300);       // JZS taken
    op1(4'd4, 20'h0, 20'h00500);       // JS back-to-back, taken

    // XSR/LSR, T untouched
    op1(4'd6, 20'h00005, 20'h0);
    op1(4'd7, 20'h0000F, 20'h0);
    chk("xsr_status", 32'(bus.status), 32'(5'b01010));
    op1(4'd6, 20'h0001F, 20'h0);
    chk("lsr_T", 32'(bus.status[4]), 32'(1'b0));

    // Illegal op traps, intake blocked, trap_clr resumes
    op1(4'd2, 20'h0, 20'h00010);
    op1(4'hF, 20'h0, 20'h0);
    chk("trap_epc", 32'(bus.epc), 32'h00011);
    for (int i = 0; i < 3; i++) op1(4'd2, 20'h0, 20'h12345);
    idle(1'b1, 1'b0);
    chk("trap_exit_pc", 32'(bus.pc), 32'h00011);
    idle(1'b1, 1'b0);                  // trap_clr in RUN ignored
    op1(4'd0, 20'h0, 20'h0);           // first op after exit

    // PC wrap
    op1(4'd2, 20'h0, 20'hFFFFF);
    op1(4'd0, 20'h0, 20'h0);
    chk("pc_wrap", 32'(bus.pc), 32'h0);

    // epc wrap on trap from the top of memory, then reset mid-trap
    op1(4'd2, 20'h0, 20'hFFFFF);
    op1(4'd8, 20'h0, 20'h0);
    step(1'b1, 4'd8, 1'b1, 20'h0, 1'b0, 1'b0, 3'b111, 20'h0, 1'b1, 1'b1);

    // Reset coincident with a transfer in RUN
    op1(4'd2, 20'h0, 20'h00777);
    step(1'b1, 4'd2, 1'b1, 20'h0, 1'b0, 1'b0, 3'b111, 20'h00999, 1'b0, 1'b1);

    // Random traffic
    for (int i = 0; i < 600; i++) begin
      logic [3:0] o;
      o = (($urandom % 8) == 0) ? 4'($urandom_range(8, 15)) : 4'($urandom_range(0, 7));
      step(1'($urandom_range(0, 3) != 0), o, 1'($urandom), 20'($urandom),
           1'($urandom), 1'($urandom), 3'($urandom), 20'($urandom),
           1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 49) == 0));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
